// File: rtl/hc138_seq_decoder.sv
// hc138_seq_decoder
// Registered 3-to-8 decoder, 74HC138 style, with active-low outputs.
// The input side takes a 74HC148-style priority encoder result: an
// active-low code plus the active-low group-select GS_n.
//
// It has two modes of operation:
//   pulse : one accepted request drives a single Y_n bit low for
//           HOLD_CYCLES cycles, then returns to idle
//   scan  : Y_n walks Y0..Y7 continuously and spends SCAN_DIV cycles on
//           each output. It is used for display and keyboard multiplexing.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | all outputs high, waiting for an enabled scan or decode request
// HOLD  | one output low, the hold counter runs down to zero
// SCAN  | walking output low, the divider paces the scan index
//
// Every output comes straight from a flop. The next-state process computes
// the next value of every register. The state register only copies them in.

module hc138_seq_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int SCAN_DIV    = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       G1,
  input  logic       G2A_n,
  input  logic       G2B_n,
  input  logic [2:0] CodeIn,
  input  logic       GS_n,
  input  logic       ScanEn,
  output logic [7:0] Y_n,
  output logic       Busy,
  output logic       Ack,
  output logic [2:0] ScanIdx
);

  // A parameter value of 1 would make $clog2 return 0. Keep at least one bit.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       y_n_q, y_n_nxt;
  logic             busy_q, busy_nxt;
  logic             ack_q, ack_nxt;
  logic [2:0]       scan_idx_q, scan_idx_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;

  logic             en;
  logic [2:0]       req_idx;
  logic [2:0]       scan_idx_inc;

  // Active-low one-hot: exactly one bit low, selected by idx.
  function automatic logic [7:0] decode_low(input logic [2:0] idx);
    logic [7:0] one;
    one        = 8'd1;
    decode_low = ~(one << idx);
  endfunction

  // Combined enable gates. The encoder code is active-low, so invert it.
  always_comb begin
    en           = G1 & ~G2A_n & ~G2B_n;
    req_idx      = ~CodeIn;
    scan_idx_inc = scan_idx_q + 3'd1;
  end

  // Next-state and next-output logic. Ack is a single-cycle strobe and
  // therefore defaults low.
  always_comb begin
    state_nxt    = state;
    y_n_nxt      = y_n_q;
    busy_nxt     = busy_q;
    ack_nxt      = 1'b0;
    scan_idx_nxt = scan_idx_q;
    cnt_nxt      = cnt_q;
    div_nxt      = div_q;

    case (state)
      IDLE: begin
        y_n_nxt      = 8'hFF;
        busy_nxt     = 1'b0;
        scan_idx_nxt = 3'd0;
        if (!en) begin
          state_nxt = IDLE;
        end else if (ScanEn) begin
          // A scan request wins over a simultaneous decode request.
          state_nxt    = SCAN;
          scan_idx_nxt = 3'd0;
          y_n_nxt      = 8'hFE;
          div_nxt      = '0;
          busy_nxt     = 1'b1;
        end else if (!GS_n) begin
          state_nxt = HOLD;
          y_n_nxt   = decode_low(req_idx);
          ack_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          cnt_nxt   = CNT_LOAD;
        end
      end

      HOLD: begin
        // Requests are ignored here. A GS_n held low is taken again on the
        // first IDLE cycle, which leaves a one-cycle gap of all-high.
        if (!en || (cnt_q == '0)) begin
          state_nxt = IDLE;
          y_n_nxt   = 8'hFF;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end

      SCAN: begin
        if (!en || !ScanEn) begin
          state_nxt    = IDLE;
          y_n_nxt      = 8'hFF;
          busy_nxt     = 1'b0;
          scan_idx_nxt = 3'd0;
          div_nxt      = '0;
        end else if (div_q == DIV_LAST) begin
          div_nxt      = '0;
          scan_idx_nxt = scan_idx_inc;
          y_n_nxt      = decode_low(scan_idx_inc);
        end else begin
          div_nxt = div_q + DIV_ONE;
        end
      end

      default: begin
        // An unreachable encoding recovers to a quiet idle.
        state_nxt    = IDLE;
        y_n_nxt      = 8'hFF;
        busy_nxt     = 1'b0;
        scan_idx_nxt = 3'd0;
        cnt_nxt      = '0;
        div_nxt      = '0;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and overrides every state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      y_n_q      <= 8'hFF;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      scan_idx_q <= 3'd0;
      cnt_q      <= '0;
      div_q      <= '0;
    end else begin
      state      <= state_nxt;
      y_n_q      <= y_n_nxt;
      busy_q     <= busy_nxt;
      ack_q      <= ack_nxt;
      scan_idx_q <= scan_idx_nxt;
      cnt_q      <= cnt_nxt;
      div_q      <= div_nxt;
    end
  end

  // Drive the ports from the flops.
  always_comb begin
    Y_n     = y_n_q;
    Busy    = busy_q;
    Ack     = ack_q;
    ScanIdx = scan_idx_q;
  end

endmodule
